// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// Shared npc definitions: AXI read-response codes, boot constants and the
// instruction-fetch FSM state encoding.
package ysyx_23060208_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [31:0] RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_fetch_if.sv
// isram read channel (AR/R). master = fetch initiator, slave = isram / arbiter.
interface ysyx_23060208_ifu_fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] isram_araddr;
  logic                  isram_arvalid;
  logic                  isram_arready;
  logic [1:0]            isram_rresp;
  logic                  isram_rvalid;
  logic [DATA_WIDTH-1:0] isram_rdata;
  logic                  isram_rready;

  // A beat transfers on the rising edge where valid and ready are both high.
  // Once valid is raised, it and its payload stay stable until ready; ready may
  // depend on valid, valid never depends on ready.
  modport master (
    output isram_araddr, isram_arvalid, isram_rready,
    input  isram_arready, isram_rresp, isram_rvalid, isram_rdata
  );

  modport slave (
    input  isram_araddr, isram_arvalid, isram_rready,
    output isram_arready, isram_rresp, isram_rvalid, isram_rdata
  );
endinterface

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch: one outstanding isram read, one-entry instruction buffer
// toward the IDU, and redirect handling that squashes a stale in-flight fetch.
module ysyx_23060208_ifu_fetch
  import ysyx_23060208_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = ysyx_23060208_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = ysyx_23060208_pkg::NOP_INST
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_23060208_ifu_fetch_if.master isram,
  input  logic                      redirect_valid,
  input  logic [DATA_WIDTH-1:0]     redirect_pc,
  input  logic                      idu_allowin,
  output logic                      ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0]     ifu_to_idu_inst,
  output logic [DATA_WIDTH-1:0]     ifu_to_idu_pc,
  output logic                      ifu_to_idu_fault,
  output fetch_state_e              state_o
);

  fetch_state_e          state_q,      state_d;
  logic [DATA_WIDTH-1:0] pc_q,         pc_d;
  logic [DATA_WIDTH-1:0] araddr_q,     araddr_d;
  logic [DATA_WIDTH-1:0] inst_q,       inst_d;
  logic [DATA_WIDTH-1:0] pc_out_q,     pc_out_d;
  logic                  fault_q,      fault_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  squash_q,     squash_d;

  logic ar_fire;
  logic r_fire;
  logic idu_fire;

  assign isram.isram_arvalid = (state_q == S_AR);
  assign isram.isram_araddr  = araddr_q;
  assign isram.isram_rready  = (state_q == S_R);

  // Gating with redirect keeps an instruction that is being flushed this cycle
  // from ever being seen as valid downstream.
  assign ifu_to_idu_valid = hold_valid_q & ~redirect_valid;
  assign ifu_to_idu_inst  = inst_q;
  assign ifu_to_idu_pc    = pc_out_q;
  assign ifu_to_idu_fault = fault_q;
  assign state_o          = state_q;

  assign ar_fire  = isram.isram_arvalid & isram.isram_arready;
  assign r_fire   = isram.isram_rvalid & isram.isram_rready;
  assign idu_fire = ifu_to_idu_valid & idu_allowin;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    araddr_d     = araddr_q;
    inst_d       = inst_q;
    pc_out_d     = pc_out_q;
    fault_d      = fault_q;
    hold_valid_d = hold_valid_q;
    squash_d     = squash_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
        state_d = S_AR;
      end
      S_AR: begin
        // The request already on the bus keeps its old address; the redirect
        // only marks the matching beat for disposal.
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
        if (ar_fire) state_d = S_R;
      end
      S_R: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
        if (r_fire) begin
          if (squash_q || redirect_valid) begin
            squash_d = 1'b0;
            state_d  = S_AR;
          end else begin
            fault_d      = resp_is_error(isram.isram_rresp);
            inst_d       = fault_d ? NOP_INST : isram.isram_rdata;
            pc_out_d     = pc_q;
            hold_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          hold_valid_d = 1'b0;
          state_d      = S_AR;
        end else if (idu_fire) begin
          pc_d         = pc_q + DATA_WIDTH'(4);
          hold_valid_d = 1'b0;
          state_d      = S_AR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Latch the bus address only on entry to AR so it cannot move mid-request.
    if (state_d == S_AR && state_q != S_AR) araddr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      araddr_q     <= RESET_PC;
      inst_q       <= '0;
      pc_out_q     <= '0;
      fault_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      squash_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      araddr_q     <= araddr_d;
      inst_q       <= inst_d;
      pc_out_q     <= pc_out_d;
      fault_q      <= fault_d;
      hold_valid_q <= hold_valid_d;
      squash_q     <= squash_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed bench for the fetch unit: a scripted isram responder and IDU sink,
// with a scoreboard of expected {fault, pc, inst} entries.
module tb_ysyx_23060208_ifu_fetch;
  import ysyx_23060208_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060208_ifu_fetch_if #(.DATA_WIDTH(32)) isram ();

  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         idu_allowin;
  logic         ifu_to_idu_valid;
  logic [31:0]  ifu_to_idu_inst;
  logic [31:0]  ifu_to_idu_pc;
  logic         ifu_to_idu_fault;
  fetch_state_e dut_state;

  ysyx_23060208_ifu_fetch #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .isram            (isram.master),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .idu_allowin      (idu_allowin),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .ifu_to_idu_inst  (ifu_to_idu_inst),
    .ifu_to_idu_pc    (ifu_to_idu_pc),
    .ifu_to_idu_fault (ifu_to_idu_fault),
    .state_o          (dut_state)
  );

  // scoreboard
  logic [64:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic do_ar(input logic [31:0] addr, input int ar_wait);
    int n = 0;
    while (isram.isram_arvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("ar_arvalid", 32'(isram.isram_arvalid), 32'd1);
    for (int i = 0; i < ar_wait; i++) begin
      isram.isram_arready = 1'b0;
      check("ar_hold_valid", 32'(isram.isram_arvalid), 32'd1);
      check("ar_hold_addr", isram.isram_araddr, addr);
      check("ar_no_rready", 32'(isram.isram_rready), 32'd0);
      step();
    end
    check("ar_addr", isram.isram_araddr, addr);
    isram.isram_arready = 1'b1;
    step();
    isram.isram_arready = 1'b0;
  endtask

  task automatic do_r(input int r_wait, input logic [31:0] data, input logic [1:0] resp,
                      input bit push, input logic [31:0] pc);
    for (int i = 0; i < r_wait; i++) begin
      check("r_rready_wait", 32'(isram.isram_rready), 32'd1);
      check("r_no_arvalid", 32'(isram.isram_arvalid), 32'd0);
      step();
    end
    check("r_rready", 32'(isram.isram_rready), 32'd1);
    isram.isram_rvalid = 1'b1;
    isram.isram_rdata  = data;
    isram.isram_rresp  = resp;
    if (push) exp_q.push_back({resp != 2'b00, pc, (resp != 2'b00) ? NOP : data});
    step();
    isram.isram_rvalid = 1'b0;
    isram.isram_rdata  = '0;
    isram.isram_rresp  = 2'b00;
  endtask

  task automatic consume(input int stall);
    int n = 0;
    logic [64:0] e;
    while (ifu_to_idu_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("idu_valid", 32'(ifu_to_idu_valid), 32'd1);
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < stall; i++) begin
      idu_allowin = 1'b0;
      check("stall_valid", 32'(ifu_to_idu_valid), 32'd1);
      check("stall_inst", ifu_to_idu_inst, e[31:0]);
      check("stall_pc", ifu_to_idu_pc, e[63:32]);
      check("stall_no_ar", 32'(isram.isram_arvalid), 32'd0);
      step();
    end
    check("idu_inst", ifu_to_idu_inst, e[31:0]);
    check("idu_pc", ifu_to_idu_pc, e[63:32]);
    check("idu_fault", 32'(ifu_to_idu_fault), 32'(e[64]));
    idu_allowin = 1'b1;
    step();
    idu_allowin = 1'b0;
  endtask

  initial begin
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    idu_allowin         = 1'b0;
    isram.isram_arready = 1'b0;
    isram.isram_rvalid  = 1'b0;
    isram.isram_rdata   = '0;
    isram.isram_rresp   = 2'b00;

    // reset state
    step();
    step();
    check("rst_state", 32'(dut_state), 32'(S_IDLE));
    check("rst_arvalid", 32'(isram.isram_arvalid), 32'd0);
    check("rst_rready", 32'(isram.isram_rready), 32'd0);
    check("rst_valid", 32'(ifu_to_idu_valid), 32'd0);
    check("rst_inst", ifu_to_idu_inst, 32'd0);
    check("rst_fault", 32'(ifu_to_idu_fault), 32'd0);

    // boot: AR one cycle after release, instruction valid at cycle 3
    rst = 1'b1;
    #1 check("boot_idle", 32'(dut_state), 32'(S_IDLE));
    step();
    check("boot_arvalid_c1", 32'(isram.isram_arvalid), 32'd1);
    check("boot_araddr_c1", isram.isram_araddr, 32'h8000_0000);
    do_ar(32'h8000_0000, 0);
    do_r(0, 32'h0010_0093, RESP_OKAY, 1'b1, 32'h8000_0000);
    check("boot_valid_c3", 32'(ifu_to_idu_valid), 32'd1);
    consume(0);

    // arready held low, then IDU stall in HOLD
    do_ar(32'h8000_0004, 5);
    do_r(0, 32'h0020_8113, RESP_OKAY, 1'b1, 32'h8000_0004);
    consume(4);

    // redirect while waiting in R: beat discarded, refetch from target
    do_ar(32'h8000_0008, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    #1 check("redir_r_valid", 32'(ifu_to_idu_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    do_r(2, 32'h0BAD_C0DE, RESP_OKAY, 1'b0, 32'h0);
    check("squash_no_valid", 32'(ifu_to_idu_valid), 32'd0);
    do_ar(32'h8000_1000, 0);
    do_r(1, 32'h0030_0193, RESP_OKAY, 1'b1, 32'h8000_1000);
    consume(0);

    // error response substitutes NOP and flags fault
    do_ar(32'h8000_1004, 0);
    do_r(0, 32'hDEAD_BEEF, RESP_SLVERR, 1'b1, 32'h8000_1004);
    consume(0);

    // redirect in HOLD wins over same-cycle allowin
    do_ar(32'h8000_1008, 1);
    do_r(0, 32'h1111_1111, RESP_OKAY, 1'b0, 32'h0);
    check("hold_valid", 32'(ifu_to_idu_valid), 32'd1);
    idu_allowin    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1 check("redir_hold_gate", 32'(ifu_to_idu_valid), 32'd0);
    step();
    idu_allowin    = 1'b0;
    redirect_valid = 1'b0;

    // PC wrap at top of address space
    do_ar(32'hFFFF_FFFC, 0);
    do_r(1, 32'h0040_0213, RESP_OKAY, 1'b1, 32'hFFFF_FFFC);
    consume(0);
    do_ar(32'h0000_0000, 0);

    // asynchronous reset in R
    #2 rst = 1'b0;
    isram.isram_rvalid = 1'b1;
    isram.isram_rdata  = 32'h5555_5555;
    #1;
    check("arst_state", 32'(dut_state), 32'(S_IDLE));
    check("arst_arvalid", 32'(isram.isram_arvalid), 32'd0);
    check("arst_rready", 32'(isram.isram_rready), 32'd0);
    check("arst_valid", 32'(ifu_to_idu_valid), 32'd0);
    step();
    rst = 1'b1;
    step();
    isram.isram_rvalid = 1'b0;
    isram.isram_rdata  = '0;
    check("arst_no_hold", 32'(ifu_to_idu_valid), 32'd0);
    do_ar(32'h8000_0000, 0);
    do_r(0, 32'h0050_0293, RESP_OKAY, 1'b1, 32'h8000_0000);
    consume(1);
    do_ar(32'h8000_0004, 0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "bench time limit");
  end

endmodule
